// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: clocked command front-end for the combinational ALU breadboard.
// Accepts a command over valid/ready, drives the ALU inputs for an op-dependent
// settle window, captures the result with op-class error masking, returns it
// over a second valid/ready handshake, and keeps saturating error event counters.
`timescale 1ns/1ps

module alu_cmd_issuer #(
    parameter int unsigned BASE_SETTLE = 2,   // ADD/SUB/DIV/MOD settle cycles, 1..255
    parameter int unsigned MUL_SETTLE  = 8,   // MUL settle cycles, 1..255
    parameter int unsigned CNT_W       = 8    // error event counter width
) (
    input  logic             CLK,
    input  logic             RST,
    // command channel
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [3:0]       CMD_OP,
    input  logic [15:0]      CMD_A,
    input  logic [15:0]      CMD_B,
    // ALU breadboard side
    output logic [15:0]      ALU_IN1,
    output logic [15:0]      ALU_IN2,
    output logic [3:0]       ALU_OP,
    input  logic [31:0]      ALU_OUT,
    input  logic [1:0]       ALU_ERR,
    // response channel
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [31:0]      RSP_DATA,
    output logic [1:0]       RSP_ERR,
    output logic             RSP_ILL,
    output logic [3:0]       RSP_OP,
    // status and counters
    output logic             BUSY,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] OVF_CNT,
    output logic [CNT_W-1:0] DZE_CNT
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;

    localparam logic [7:0] BASE_CNT = 8'(BASE_SETTLE);
    localparam logic [7:0] MUL_CNT  = 8'(MUL_SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [15:0]      alu_in1_q, alu_in2_q;
    logic [3:0]       alu_op_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic [1:0]       rsp_err_q;
    logic             rsp_ill_q;
    logic [3:0]       rsp_op_q;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] dze_cnt_q, dze_cnt_d;

    logic             capture;
    logic [1:0]       err_masked;
    logic             cmd_legal;

    assign cmd_legal = (CMD_OP >= OP_ADD) && (CMD_OP <= OP_MOD);
    assign capture   = (state_q == S_SETTLE) && (cnt_q == 8'd1);

    // Mask ALU errors by op class and compute saturating counter next values.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        err_masked = 2'b00;
        ovf_cnt_d  = ovf_cnt_q;
        dze_cnt_d  = dze_cnt_q;
        if ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) err_masked[0] = ALU_ERR[0];
        if ((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) err_masked[1] = ALU_ERR[1];
        if (CNT_CLR) begin
            // clear wins over a same-cycle increment
            ovf_cnt_d = '0;
            dze_cnt_d = '0;
        end else if (capture) begin
            if (err_masked[0] && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            if (err_masked[1] && (dze_cnt_q != '1)) dze_cnt_d = dze_cnt_q + CNT_W'(1);
        end
    end

    // Error event counters.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_cnt_q <= '0;
            dze_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            dze_cnt_q <= dze_cnt_d;
        end
    end

    // Command FSM with registered ALU drive and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= 4'b0000;   // grounded channel
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 2'b00;
            rsp_ill_q   <= 1'b0;
            rsp_op_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        rsp_op_q <= CMD_OP;
                        if (cmd_legal) begin
                            alu_in1_q <= CMD_A;
                            alu_in2_q <= CMD_B;
                            alu_op_q  <= CMD_OP;
                            cnt_q     <= (CMD_OP == OP_MUL) ? MUL_CNT : BASE_CNT;
                            state_q   <= S_SETTLE;
                        end else begin
                            // illegal op: ALU drive untouched, answer at once
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 2'b00;
                            rsp_ill_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_SETTLE: begin
                    if (capture) begin
                        rsp_data_q  <= ALU_OUT;
                        rsp_err_q   <= err_masked;
                        rsp_ill_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY = (state_q == S_IDLE);
    assign BUSY      = ~CMD_READY;
    assign ALU_IN1   = alu_in1_q;
    assign ALU_IN2   = alu_in2_q;
    assign ALU_OP    = alu_op_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_ILL   = rsp_ill_q;
    assign RSP_OP    = rsp_op_q;
    assign OVF_CNT   = ovf_cnt_q;
    assign DZE_CNT   = dze_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer with a behavioural model
// of the ALU breadboard and a queue of expected responses.
`timescale 1ns/1ps

module tb_alu_cmd_issuer;

    localparam int BASE = 2;
    localparam int MULS = 8;
    localparam int CW   = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CMD_VALID, CMD_READY;
    logic [3:0]    CMD_OP;
    logic [15:0]   CMD_A, CMD_B;
    logic [15:0]   ALU_IN1, ALU_IN2;
    logic [3:0]    ALU_OP;
    logic [31:0]   ALU_OUT;
    logic [1:0]    ALU_ERR;
    logic          RSP_VALID, RSP_READY;
    logic [31:0]   RSP_DATA;
    logic [1:0]    RSP_ERR;
    logic          RSP_ILL;
    logic [3:0]    RSP_OP;
    logic          BUSY, CNT_CLR;
    logic [CW-1:0] OVF_CNT, DZE_CNT;

    always #5 CLK = ~CLK;

    alu_cmd_issuer #(.BASE_SETTLE(BASE), .MUL_SETTLE(MULS), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_OP(ALU_OP),
        .ALU_OUT(ALU_OUT), .ALU_ERR(ALU_ERR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR), .RSP_ILL(RSP_ILL), .RSP_OP(RSP_OP),
        .BUSY(BUSY), .CNT_CLR(CNT_CLR), .OVF_CNT(OVF_CNT), .DZE_CNT(DZE_CNT)
    );

    // Breadboard model: ERR[1] follows IN2==0 for every op, ERR[0] flags
    // unsigned carry/borrow on ADD/SUB.
    always_comb begin
        ALU_OUT = 32'd0;
        ALU_ERR = 2'b00;
        ALU_ERR[1] = (ALU_IN2 == 16'd0);
        case (ALU_OP)
            4'b0010: begin
                ALU_OUT    = {16'd0, ALU_IN1} + {16'd0, ALU_IN2};
                ALU_ERR[0] = ALU_OUT[16];
            end
            4'b0011: begin
                ALU_OUT    = {16'd0, ALU_IN1} - {16'd0, ALU_IN2};
                ALU_ERR[0] = (ALU_IN1 < ALU_IN2);
            end
            4'b0100: ALU_OUT = {16'd0, ALU_IN1} * {16'd0, ALU_IN2};
            4'b0101: ALU_OUT = (ALU_IN2 == 16'd0) ? 32'd0 : {16'd0, ALU_IN1 / ALU_IN2};
            4'b0110: ALU_OUT = (ALU_IN2 == 16'd0) ? 32'd0 : {16'd0, ALU_IN1 % ALU_IN2};
            default: ALU_OUT = 32'd0;
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        legal;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;   // first cycle RSP_VALID is seen; cycle 1 follows the accept edge
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a command until accepted; optionally record the expected response.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] data, input logic [1:0] err, input int lat,
                         input bit push);
        exp_t e;
        int   w = 0;
        while (!CMD_READY && w < 100) begin
            step();
            w++;
        end
        check("cmd_ready_wait", CMD_READY, 1'b1);
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.legal = (op >= 4'd2) && (op <= 4'd6);
        e.data  = data;
        e.err   = err;
        e.lat   = lat;
        if (push) sb.push_back(e);
        CMD_OP    = op;
        CMD_A     = a;
        CMD_B     = b;
        CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
    endtask

    // Wait for the response, compare against the queue head, optionally hold
    // RSP_READY low while poking CMD_VALID, then complete the handshake.
    task automatic collect(input int start_lat, input int hold);
        exp_t        e;
        int          lat    = start_lat;
        bit          alu_ok = 1'b1;
        bit          hold_ok = 1'b1;
        logic [31:0] s_data;
        logic [1:0]  s_err;
        logic        s_ill;
        logic [3:0]  s_op;
        e = sb.pop_front();
        while (!RSP_VALID && lat < 64) begin
            if (e.legal && (ALU_IN1 !== e.a || ALU_IN2 !== e.b || ALU_OP !== e.op)) alu_ok = 1'b0;
            step();
            lat++;
        end
        check("rsp_valid", RSP_VALID, 1'b1);
        check("latency", lat, e.lat);
        check("rsp_data", RSP_DATA, e.data);
        check("rsp_err", RSP_ERR, e.err);
        check("rsp_ill", RSP_ILL, !e.legal);
        check("rsp_op", RSP_OP, e.op);
        if (e.legal) check("alu_stable", alu_ok, 1'b1);
        if (hold > 0) begin
            s_data = RSP_DATA;
            s_err  = RSP_ERR;
            s_ill  = RSP_ILL;
            s_op   = RSP_OP;
            for (int i = 0; i < hold; i++) begin
                CMD_VALID = (i % 2 == 0);
                CMD_OP    = 4'b0010;
                CMD_A     = 16'd1;
                CMD_B     = 16'd1;
                step();
                if (!RSP_VALID || CMD_READY || RSP_DATA !== s_data || RSP_ERR !== s_err ||
                    RSP_ILL !== s_ill || RSP_OP !== s_op) hold_ok = 1'b0;
            end
            CMD_VALID = 1'b0;
            check("hold_stable", hold_ok, 1'b1);
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        check("rsp_drop", RSP_VALID, 1'b0);
        check("ready_after", CMD_READY, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_A = '0; CMD_B = '0;
        RSP_READY = 1'b0; CNT_CLR = 1'b0;
        step();
        step();
        RST = 1'b0;

        // reset state
        check("rst_cmd_ready", CMD_READY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_rsp_valid", RSP_VALID, 1'b0);
        check("rst_alu_in1", ALU_IN1, 16'd0);
        check("rst_alu_in2", ALU_IN2, 16'd0);
        check("rst_alu_op", ALU_OP, 4'd0);
        check("rst_rsp_data", RSP_DATA, 32'd0);
        check("rst_rsp_err", RSP_ERR, 2'd0);
        check("rst_rsp_ill", RSP_ILL, 1'b0);
        check("rst_rsp_op", RSP_OP, 4'd0);
        check("rst_ovf", OVF_CNT, 0);
        check("rst_dze", DZE_CNT, 0);

        // ADD 11+51
        issue(4'b0010, 16'd11, 16'd51, 32'd62, 2'b00, BASE + 1, 1'b1);
        check("add_busy", BUSY, 1'b1);
        collect(1, 0);

        // SUB 11-51: borrow flagged as overflow
        issue(4'b0011, 16'd11, 16'd51, 32'hFFFF_FFD8, 2'b01, BASE + 1, 1'b1);
        collect(1, 0);
        check("sub_ovf_cnt", OVF_CNT, 1);

        // ADD 5+0: breadboard raises ERR[1], masked for ADD
        issue(4'b0010, 16'd5, 16'd0, 32'd5, 2'b00, BASE + 1, 1'b1);
        collect(1, 0);
        check("add0_dze_cnt", DZE_CNT, 0);
        check("add0_ovf_cnt", OVF_CNT, 1);

        // MUL 11*51 with long settle
        issue(4'b0100, 16'd11, 16'd51, 32'd561, 2'b00, MULS + 1, 1'b1);
        collect(1, 0);

        // illegal op answers next cycle, ALU drive unchanged
        issue(4'b1001, 16'd7, 16'd7, 32'd0, 2'b00, 1, 1'b1);
        check("ill_alu_op_held", ALU_OP, 4'b0100);
        check("ill_alu_in1_held", ALU_IN1, 16'd11);
        collect(1, 0);
        check("ill_alu_op_after", ALU_OP, 4'b0100);
        check("ill_ovf_cnt", OVF_CNT, 1);

        // DIV and MOD with a nonzero divisor
        issue(4'b0101, 16'd51, 16'd11, 32'd4, 2'b00, BASE + 1, 1'b1);
        collect(1, 0);
        issue(4'b0110, 16'd51, 16'd11, 32'd7, 2'b00, BASE + 1, 1'b1);
        collect(1, 0);

        // DIV by zero
        issue(4'b0101, 16'd11, 16'd0, 32'd0, 2'b10, BASE + 1, 1'b1);
        collect(1, 0);
        check("div0_dze_cnt", DZE_CNT, 1);

        // 299 more: counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            issue(4'b0101, 16'd11, 16'd0, 32'd0, 2'b10, BASE + 1, 1'b1);
            collect(1, 0);
        end
        check("dze_saturated", DZE_CNT, 255);
        check("ovf_unchanged", OVF_CNT, 1);

        // plain clear
        CNT_CLR = 1'b1;
        step();
        CNT_CLR = 1'b0;
        check("clr_dze", DZE_CNT, 0);
        check("clr_ovf", OVF_CNT, 0);

        // clear coinciding with the capture edge of a DIV by zero
        issue(4'b0101, 16'd11, 16'd0, 32'd0, 2'b10, BASE + 1, 1'b1);
        step();
        CNT_CLR = 1'b1;
        step();
        CNT_CLR = 1'b0;
        check("clr_wins_dze", DZE_CNT, 0);
        collect(BASE + 1, 0);

        // increment resumes after clear
        issue(4'b0101, 16'd11, 16'd0, 32'd0, 2'b10, BASE + 1, 1'b1);
        collect(1, 0);
        check("post_clr_dze", DZE_CNT, 1);

        // backpressure: hold RSP_READY low 5 cycles with CMD_VALID pulses
        issue(4'b0010, 16'd100, 16'd200, 32'd300, 2'b00, BASE + 1, 1'b1);
        collect(1, 5);
        step();
        check("no_ghost_rsp", RSP_VALID, 1'b0);
        check("no_ghost_accept", CMD_READY, 1'b1);

        // reset during SETTLE drops the command
        issue(4'b0100, 16'd3, 16'd4, 32'd12, 2'b00, MULS + 1, 1'b0);
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mid_rst_valid", RSP_VALID, 1'b0);
        check("mid_rst_alu_op", ALU_OP, 4'd0);
        check("mid_rst_alu_in1", ALU_IN1, 16'd0);
        check("mid_rst_ready", CMD_READY, 1'b1);
        check("mid_rst_dze", DZE_CNT, 0);
        begin
            bit quiet = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step();
                if (RSP_VALID !== 1'b0) quiet = 1'b0;
            end
            check("mid_rst_no_rsp", quiet, 1'b1);
        end
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
